cc_alu_arbiter: RTL and testbench

- Sequencer/arbiter that shares the single 32-bit CC ALU between two requesters: requester 0 is the microcode datapath and requester 1 is the PC/address unit.
- Arbitrates round-robin, registers the operands and selection into the ALU, and captures the result and flags into a response register.
- Maintains the processor's NZVC condition-code register (PSR) for the CC-class operations, selection 0–3, i.e. whenever the ALU asserts SCC.
- Sits between the control unit and the combinational ALU. The ALU itself is instantiated externally.

---
 rtl/cc_alu_pkg.sv | 45 ++++
 rtl/cc_rr_arbiter2.sv | 32 +++
 rtl/cc_alu_arbiter.sv | 136 +++++++++++++
 tb/tb_cc_alu_arbiter.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/cc_alu_pkg.sv
// Shared definitions for the CC ALU arbiter: ALU selection codes, flag bit indices, FSM states.
// Optional condition-code register feature: CC_ALU_ARB_PSR_EN.
package cc_alu_pkg;

  localparam logic [3:0] ALU_ANDCC    = 4'd0;
  localparam logic [3:0] ALU_ORCC     = 4'd1;
  localparam logic [3:0] ALU_ORNCC    = 4'd2;
  localparam logic [3:0] ALU_ADCC     = 4'd3;
  localparam logic [3:0] ALU_SRL      = 4'd4;
  localparam logic [3:0] ALU_AND      = 4'd5;
  localparam logic [3:0] ALU_OR       = 4'd6;
  localparam logic [3:0] ALU_ORN      = 4'd7;
  localparam logic [3:0] ALU_ADD      = 4'd8;
  localparam logic [3:0] ALU_LSHIFT2  = 4'd9;
  localparam logic [3:0] ALU_LSHIFT10 = 4'd10;
  localparam logic [3:0] ALU_SIMM13   = 4'd11;
  localparam logic [3:0] ALU_SEXT13   = 4'd12;
  localparam logic [3:0] ALU_INC      = 4'd13;
  localparam logic [3:0] ALU_INCPC    = 4'd14;
  localparam logic [3:0] ALU_RSHIFT5  = 4'd15;

  localparam int unsigned FLAG_N = 3;
  localparam int unsigned FLAG_Z = 2;
  localparam int unsigned FLAG_V = 1;
  localparam int unsigned FLAG_C = 0;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } arbState_t;

  // Winner index among two requests; on a tie the pointer names the winner.
  function automatic logic rrPick(input logic [1:0] req, input logic ptr);
    logic idx;
    unique case (req)
      2'b01:   idx = 1'b0;
      2'b10:   idx = 1'b1;
      2'b11:   idx = ptr;
      default: idx = 1'b0;
    endcase
    return idx;
  endfunction

endpackage

// File: rtl/cc_rr_arbiter2.sv
// Two-way round-robin grant with a registered priority pointer.
// The pointer moves to the non-served requester when a transaction retires.
module cc_rr_arbiter2
  import cc_alu_pkg::*;
(
  input  logic       clock,
  input  logic       reset,
  input  logic       enable,
  input  logic [1:0] reqValid,
  input  logic       advance,
  input  logic       advanceIdx,
  output logic [1:0] grant
);

  logic pointerReg;

  always_ff @(posedge clock) begin
    if (reset) begin
      pointerReg <= 1'b0;
    end else if (advance) begin
      pointerReg <= ~advanceIdx;
    end
  end

  always_comb begin
    grant = '0;
    if (enable && (|reqValid)) begin
      grant[rrPick(reqValid, pointerReg)] = 1'b1;
    end
  end

endmodule

// File: rtl/cc_alu_arbiter.sv
// Shares the external CC ALU between the microcode datapath (req0) and the PC/address unit (req1).
// Define CC_ALU_ARB_PSR_EN to add the NZVC condition-code register and its output port.
module cc_alu_arbiter
  import cc_alu_pkg::*;
#(
  parameter int unsigned DATAWIDTH_BUS           = 32,
  parameter int unsigned DATAWIDTH_ALU_SELECTION = 4,
  parameter int unsigned DATAWIDTH_FLAGS         = 4
) (
  input  logic                               CC_ALUARB_CLOCK_50,
  input  logic                               CC_ALUARB_RESET_InHigh,
  input  logic                               CC_ALUARB_req0Valid_InHigh,
  output logic                               CC_ALUARB_req0Ready_OutHigh,
  input  logic [DATAWIDTH_ALU_SELECTION-1:0] CC_ALUARB_req0Sel_InBUS,
  input  logic [DATAWIDTH_BUS-1:0]           CC_ALUARB_req0DataA_InBUS,
  input  logic [DATAWIDTH_BUS-1:0]           CC_ALUARB_req0DataB_InBUS,
  input  logic                               CC_ALUARB_req1Valid_InHigh,
  output logic                               CC_ALUARB_req1Ready_OutHigh,
  input  logic [DATAWIDTH_ALU_SELECTION-1:0] CC_ALUARB_req1Sel_InBUS,
  input  logic [DATAWIDTH_BUS-1:0]           CC_ALUARB_req1DataA_InBUS,
  input  logic [DATAWIDTH_BUS-1:0]           CC_ALUARB_req1DataB_InBUS,
  output logic                               CC_ALUARB_resp0Valid_OutHigh,
  output logic                               CC_ALUARB_resp1Valid_OutHigh,
  input  logic                               CC_ALUARB_resp0Ready_InHigh,
  input  logic                               CC_ALUARB_resp1Ready_InHigh,
  output logic [DATAWIDTH_BUS-1:0]           CC_ALUARB_respData_OutBUS,
  output logic [DATAWIDTH_FLAGS-1:0]         CC_ALUARB_respFlags_OutBUS,
  output logic [DATAWIDTH_BUS-1:0]           CC_ALUARB_aluDataA_OutBUS,
  output logic [DATAWIDTH_BUS-1:0]           CC_ALUARB_aluDataB_OutBUS,
  output logic [DATAWIDTH_ALU_SELECTION-1:0] CC_ALUARB_aluSel_OutBUS,
  input  logic [DATAWIDTH_BUS-1:0]           CC_ALUARB_aluData_InBUS,
  input  logic [DATAWIDTH_FLAGS-1:0]         CC_ALUARB_aluFlags_InBUS,
  input  logic                               CC_ALUARB_aluSCC_InHigh
`ifdef CC_ALU_ARB_PSR_EN
  ,
  output logic [DATAWIDTH_FLAGS-1:0]         CC_ALUARB_psr_OutBUS
`endif
);

  arbState_t                          stateReg;
  logic                               grantIdxReg;
  logic [1:0]                         respValidReg;
  logic [DATAWIDTH_BUS-1:0]           respDataReg;
  logic [DATAWIDTH_FLAGS-1:0]         respFlagsReg;
  logic [DATAWIDTH_BUS-1:0]           aluDataAReg;
  logic [DATAWIDTH_BUS-1:0]           aluDataBReg;
  logic [DATAWIDTH_ALU_SELECTION-1:0] aluSelReg;

  logic [1:0] grant;
  logic       acceptEnable;
  logic       respReadySel;
  logic       respDone;

  // Reset also masks the combinational ready so nothing is accepted on a reset edge.
  assign acceptEnable = (stateReg == IDLE) && !CC_ALUARB_RESET_InHigh;
  assign respReadySel = grantIdxReg ? CC_ALUARB_resp1Ready_InHigh : CC_ALUARB_resp0Ready_InHigh;
  assign respDone     = (stateReg == RESP) && respReadySel;

  cc_rr_arbiter2 uArbiter (
    .clock      (CC_ALUARB_CLOCK_50),
    .reset      (CC_ALUARB_RESET_InHigh),
    .enable     (acceptEnable),
    .reqValid   ({CC_ALUARB_req1Valid_InHigh, CC_ALUARB_req0Valid_InHigh}),
    .advance    (respDone),
    .advanceIdx (grantIdxReg),
    .grant      (grant)
  );

`ifdef CC_ALU_ARB_PSR_EN
  logic [DATAWIDTH_FLAGS-1:0] psrReg;
  assign CC_ALUARB_psr_OutBUS = psrReg;
`else
  logic unusedScc;
  assign unusedScc = CC_ALUARB_aluSCC_InHigh;
`endif

  always_ff @(posedge CC_ALUARB_CLOCK_50) begin
    if (CC_ALUARB_RESET_InHigh) begin
      stateReg     <= IDLE;
      grantIdxReg  <= 1'b0;
      respValidReg <= '0;
      respDataReg  <= '0;
      respFlagsReg <= '0;
      aluDataAReg  <= '0;
      aluDataBReg  <= '0;
      aluSelReg    <= '0;
`ifdef CC_ALU_ARB_PSR_EN
      psrReg       <= '0;
`endif
    end else begin
      unique case (stateReg)
        IDLE: begin
          if (|grant) begin
            aluSelReg   <= grant[1] ? CC_ALUARB_req1Sel_InBUS   : CC_ALUARB_req0Sel_InBUS;
            aluDataAReg <= grant[1] ? CC_ALUARB_req1DataA_InBUS : CC_ALUARB_req0DataA_InBUS;
            aluDataBReg <= grant[1] ? CC_ALUARB_req1DataB_InBUS : CC_ALUARB_req0DataB_InBUS;
            grantIdxReg <= grant[1];
            stateReg    <= EXEC;
          end
        end
        EXEC: begin
          respDataReg  <= CC_ALUARB_aluData_InBUS;
          respFlagsReg <= CC_ALUARB_aluFlags_InBUS;
          respValidReg <= grantIdxReg ? 2'b10 : 2'b01;
`ifdef CC_ALU_ARB_PSR_EN
          if (CC_ALUARB_aluSCC_InHigh) begin
            psrReg <= CC_ALUARB_aluFlags_InBUS;
          end
`endif
          stateReg     <= RESP;
        end
        RESP: begin
          if (respReadySel) begin
            respValidReg <= '0;
            stateReg     <= IDLE;
          end
        end
        default: begin
          respValidReg <= '0;
          stateReg     <= IDLE;
        end
      endcase
    end
  end

  assign CC_ALUARB_req0Ready_OutHigh  = grant[0];
  assign CC_ALUARB_req1Ready_OutHigh  = grant[1];
  assign CC_ALUARB_resp0Valid_OutHigh = respValidReg[0];
  assign CC_ALUARB_resp1Valid_OutHigh = respValidReg[1];
  assign CC_ALUARB_respData_OutBUS    = respDataReg;
  assign CC_ALUARB_respFlags_OutBUS   = respFlagsReg;
  assign CC_ALUARB_aluDataA_OutBUS    = aluDataAReg;
  assign CC_ALUARB_aluDataB_OutBUS    = aluDataBReg;
  assign CC_ALUARB_aluSel_OutBUS      = aluSelReg;

endmodule

// File: tb/tb_cc_alu_arbiter.sv
// Scoreboard bench for cc_alu_arbiter with a behavioural ALU attached to the ALU-drive ports.
// Works with or without CC_ALU_ARB_PSR_EN.
module tb_cc_alu_arbiter;

  logic        clk;
  logic        rst;
  logic        v0, v1, rdy0, rdy1;
  logic [3:0]  s0, s1;
  logic [31:0] a0, b0, a1, b1;
  logic        rv0, rv1, rr0, rr1;
  logic [31:0] rData;
  logic [3:0]  rFlags;
  logic [31:0] aA, aB;
  logic [3:0]  aSel;
  logic [31:0] aluRes;
  logic [3:0]  aluFl;
  logic        aluScc;
`ifdef CC_ALU_ARB_PSR_EN
  logic [3:0]  psr;
`endif

  cc_alu_arbiter dut (
    .CC_ALUARB_CLOCK_50           (clk),
    .CC_ALUARB_RESET_InHigh       (rst),
    .CC_ALUARB_req0Valid_InHigh   (v0),
    .CC_ALUARB_req0Ready_OutHigh  (rdy0),
    .CC_ALUARB_req0Sel_InBUS      (s0),
    .CC_ALUARB_req0DataA_InBUS    (a0),
    .CC_ALUARB_req0DataB_InBUS    (b0),
    .CC_ALUARB_req1Valid_InHigh   (v1),
    .CC_ALUARB_req1Ready_OutHigh  (rdy1),
    .CC_ALUARB_req1Sel_InBUS      (s1),
    .CC_ALUARB_req1DataA_InBUS    (a1),
    .CC_ALUARB_req1DataB_InBUS    (b1),
    .CC_ALUARB_resp0Valid_OutHigh (rv0),
    .CC_ALUARB_resp1Valid_OutHigh (rv1),
    .CC_ALUARB_resp0Ready_InHigh  (rr0),
    .CC_ALUARB_resp1Ready_InHigh  (rr1),
    .CC_ALUARB_respData_OutBUS    (rData),
    .CC_ALUARB_respFlags_OutBUS   (rFlags),
    .CC_ALUARB_aluDataA_OutBUS    (aA),
    .CC_ALUARB_aluDataB_OutBUS    (aB),
    .CC_ALUARB_aluSel_OutBUS      (aSel),
    .CC_ALUARB_aluData_InBUS      (aluRes),
    .CC_ALUARB_aluFlags_InBUS     (aluFl),
    .CC_ALUARB_aluSCC_InHigh      (aluScc)
`ifdef CC_ALU_ARB_PSR_EN
    ,
    .CC_ALUARB_psr_OutBUS         (psr)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Returns {scc, flags{N,Z,V,C}, result}.
  function automatic logic [36:0] refAlu(input logic [3:0] sel, input logic [31:0] a,
                                         input logic [31:0] b);
    logic [32:0] sum;
    logic [31:0] r, addB;
    logic        isAdd, v, c;
    isAdd = 1'b0;
    addB  = b;
    r     = 32'd0;
    v     = 1'b0;
    c     = 1'b0;
    case (sel)
      4'd0, 4'd5:   r = a & b;
      4'd1, 4'd6:   r = a | b;
      4'd2, 4'd7:   r = ~(a | b);
      4'd3, 4'd8:   isAdd = 1'b1;
      4'd4:         r = a >> b[4:0];
      4'd9:         r = a << 2;
      4'd10:        r = a << 10;
      4'd11, 4'd12: r = {{19{a[12]}}, a[12:0]};
      4'd13:        begin isAdd = 1'b1; addB = 32'd1; end
      4'd14:        begin isAdd = 1'b1; addB = 32'd4; end
      default:      r = a >> 5;
    endcase
    if (isAdd) begin
      sum = {1'b0, a} + {1'b0, addB};
      r   = sum[31:0];
      c   = sum[32];
      v   = (a[31] == addB[31]) && (r[31] != a[31]);
    end
    return {(sel < 4'd4), r[31], (r == 32'd0), v, c, r};
  endfunction

  always_comb {aluScc, aluFl, aluRes} = refAlu(aSel, aA, aB);

  typedef struct {
    logic        idx;
    logic [31:0] data;
    logic [3:0]  flags;
    logic [3:0]  psr;
    int          acc;
  } expT;

  expT  q[$];
  expT  e;
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  bit   headSeen = 0;
  bit   mBusy = 0;
  logic mPtr = 1'b0;
  logic [3:0] mPsr = 4'd0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Drive one cycle at the falling edge, check ready, and record any accepted operation.
  task automatic step(input logic [1:0] vv, input logic [3:0] sl0, input logic [31:0] da0,
                      input logic [31:0] db0, input logic [3:0] sl1, input logic [31:0] da1,
                      input logic [31:0] db1, input logic [1:0] rr, input logic rs);
    logic [1:0]  expRdy;
    logic [36:0] res;
    expT         ne;
    @(negedge clk);
    rst = rs;
    v0 = vv[0]; s0 = sl0; a0 = da0; b0 = db0;
    v1 = vv[1]; s1 = sl1; a1 = da1; b1 = db1;
    rr0 = rr[0]; rr1 = rr[1];
    if (rs) begin
      q.delete();
      headSeen = 0;
      mBusy    = 0;
      mPtr     = 1'b0;
      mPsr     = 4'd0;
    end
    #1;
    expRdy = 2'b00;
    if (!rs && !mBusy) begin
      if (vv == 2'b11) expRdy = mPtr ? 2'b10 : 2'b01;
      else             expRdy = vv;
    end
    chk("req_ready", {30'd0, rdy1, rdy0}, {30'd0, expRdy});
    if (expRdy != 2'b00) begin
      ne.idx = expRdy[1];
      res    = ne.idx ? refAlu(sl1, da1, db1) : refAlu(sl0, da0, db0);
      if (res[36]) mPsr = res[35:32];
      ne.data  = res[31:0];
      ne.flags = res[35:32];
      ne.psr   = mPsr;
      ne.acc   = cyc;
      q.push_back(ne);
      mBusy = 1;
    end
  endtask

  task automatic checkClean();
    chk("rst_valid", {30'd0, rv1, rv0}, 32'd0);
    chk("rst_data", rData, 32'd0);
    chk("rst_flags", {28'd0, rFlags}, 32'd0);
    chk("rst_alu_drive", aA | aB | {28'd0, aSel}, 32'd0);
`ifdef CC_ALU_ARB_PSR_EN
    chk("rst_psr", {28'd0, psr}, 32'd0);
`endif
  endtask

  // Monitor: compares the presented response against the scoreboard head.
  always @(negedge clk) begin
    #2;
    if (!rst) begin
      if (rv0 || rv1) begin
        if (q.size() == 0) begin
          chk("spurious_valid", {30'd0, rv1, rv0}, 32'd0);
        end else begin
          e = q[0];
          chk("valid_route", {30'd0, rv1, rv0}, e.idx ? 32'd2 : 32'd1);
          if (!headSeen) begin
            chk("latency", cyc, e.acc + 2);
            headSeen = 1;
          end
          chk("resp_data", rData, e.data);
          chk("resp_flags", {28'd0, rFlags}, {28'd0, e.flags});
`ifdef CC_ALU_ARB_PSR_EN
          chk("psr", {28'd0, psr}, {28'd0, e.psr});
`endif
          if (e.idx ? rr1 : rr0) begin
            void'(q.pop_front());
            headSeen = 0;
            mBusy    = 0;
            mPtr     = ~e.idx;
          end
        end
      end else if (q.size() != 0 && cyc >= q[0].acc + 2) begin
        chk("valid_missing", {30'd0, rv1, rv0}, q[0].idx ? 32'd2 : 32'd1);
      end
    end
  end

  logic [31:0] edgeVals [4];

  initial begin
    edgeVals[0] = 32'h0000_0000;
    edgeVals[1] = 32'hFFFF_FFFF;
    edgeVals[2] = 32'h7FFF_FFFF;
    edgeVals[3] = 32'h8000_0000;
    rst = 1'b1;
    {v0, v1, rr0, rr1} = '0;
    {s0, s1, a0, b0, a1, b1} = '0;
    step(2'b00, 0, 0, 0, 0, 0, 0, 2'b00, 1);
    step(2'b00, 0, 0, 0, 0, 0, 0, 2'b00, 1);
    checkClean();

    // ADCC overflow into the sign bit on req0
    step(2'b01, 4'd3, 32'h7FFF_FFFF, 32'h1, 0, 0, 0, 2'b00, 0);
    step(2'b00, 0, 0, 0, 0, 0, 0, 2'b00, 0);
    step(2'b00, 0, 0, 0, 0, 0, 0, 2'b01, 0);
    // ADD with carry-out on req1; psr must not move
    step(2'b10, 0, 0, 0, 4'd8, 32'hFFFF_FFFF, 32'h1, 2'b00, 0);
    step(2'b00, 0, 0, 0, 0, 0, 0, 2'b00, 0);
    step(2'b00, 0, 0, 0, 0, 0, 0, 2'b10, 0);

    // Ties from reset alternate req0, req1, req0
    step(2'b00, 0, 0, 0, 0, 0, 0, 2'b00, 1);
    for (int i = 0; i < 9; i++) step(2'b11, 4'd13, 32'd5, 0, 4'd13, 32'd9, 0, 2'b11, 0);

    // Held response: req1 waits, non-granted resp ready ignored
    step(2'b01, 4'd0, 32'hF0F0_1234, 32'h0FF0_FFFF, 0, 0, 0, 2'b00, 0);
    step(2'b10, 0, 0, 0, 4'd8, 32'd3, 32'd4, 2'b00, 0);
    for (int i = 0; i < 3; i++) step(2'b10, 0, 0, 0, 4'd8, 32'd3, 32'd4, 2'b10, 0);
    step(2'b10, 0, 0, 0, 4'd8, 32'd3, 32'd4, 2'b01, 0);
    for (int i = 0; i < 3; i++) step(2'b10, 0, 0, 0, 4'd8, 32'd3, 32'd4, 2'b11, 0);

    // Operands change right after accept
    step(2'b01, 4'd8, 32'd100, 32'd200, 0, 0, 0, 2'b00, 0);
    step(2'b01, 4'd8, 32'd999, 32'd999, 0, 0, 0, 2'b00, 0);
    step(2'b00, 4'd2, 32'd7, 32'd7, 0, 0, 0, 2'b01, 0);

    // Reset in EXEC after psr has been set
    step(2'b01, 4'd3, 32'h7FFF_FFFF, 32'h1, 0, 0, 0, 2'b00, 0);
    step(2'b00, 0, 0, 0, 0, 0, 0, 2'b00, 0);
    step(2'b00, 0, 0, 0, 0, 0, 0, 2'b01, 0);
    step(2'b01, 4'd8, 32'd1, 32'd2, 0, 0, 0, 2'b00, 0);
    step(2'b00, 0, 0, 0, 0, 0, 0, 2'b00, 1);
    step(2'b00, 0, 0, 0, 0, 0, 0, 2'b00, 0);
    checkClean();
    // Reset in RESP with psr freshly set
    step(2'b01, 4'd3, 32'h7FFF_FFFF, 32'h1, 0, 0, 0, 2'b00, 0);
    step(2'b00, 0, 0, 0, 0, 0, 0, 2'b00, 0);
    step(2'b00, 0, 0, 0, 0, 0, 0, 2'b00, 1);
    step(2'b00, 0, 0, 0, 0, 0, 0, 2'b00, 0);
    checkClean();
    // Pointer back at req0
    for (int i = 0; i < 3; i++) step(2'b11, 4'd14, 32'd40, 0, 4'd14, 32'd80, 0, 2'b11, 0);

    for (int i = 0; i < 500; i++) begin
      logic [31:0] ra0, rb0, ra1, rb1;
      ra0 = ($urandom_range(0, 3) == 0) ? edgeVals[$urandom_range(0, 3)] : $urandom;
      rb0 = ($urandom_range(0, 3) == 0) ? edgeVals[$urandom_range(0, 3)] : $urandom;
      ra1 = ($urandom_range(0, 3) == 0) ? edgeVals[$urandom_range(0, 3)] : $urandom;
      rb1 = ($urandom_range(0, 3) == 0) ? edgeVals[$urandom_range(0, 3)] : $urandom;
      step(2'($urandom), 4'($urandom), ra0, rb0, 4'($urandom), ra1, rb1,
           {($urandom_range(0, 3) != 0), ($urandom_range(0, 3) != 0)},
           ($urandom_range(0, 99) == 0));
    end

    for (int i = 0; i < 20 && (q.size() != 0 || mBusy); i++) begin
      step(2'b00, 0, 0, 0, 0, 0, 0, 2'b11, 0);
    end
    chk("drain", q.size(), 32'd0);

    $display("[TB] %0d tests run, %0d failed", checks, errors);
    $finish;
  end

endmodule
